// File: rtl/sha256_msg_padder_if.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder_if
// Bundles the message-word stream and the block bus of the SHA-256 padder.
//   in_valid / in_ready : word handshake from the message source
//   in_data             : big-endian message word, first byte in [31:24]
//   in_last / in_bytes  : final-word marker and its count of valid bytes
//   blk_data            : 512-bit block, word i at [32*i +: 32]
//   blk_start           : one-cycle start pulse to the compression core
//   blk_first/blk_last  : block opens / closes a message
//   blk_done            : core completion level
// Modports: slave is the padder's view, master is the environment's view
// (message source plus compression core).
// ---------------------------------------------------------------------------
interface sha256_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] blk_data;
  logic         blk_start;
  logic         blk_first;
  logic         blk_last;
  logic         blk_done;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_done,
    output in_ready, blk_data, blk_start, blk_first, blk_last
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_done,
    input  in_ready, blk_data, blk_start, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
// Takes a message as a stream of 32-bit big-endian words, applies SHA-256
// padding (0x80 marker, zero fill, 64-bit bit length) and presents complete
// 512-bit blocks to the compression core, holding each until it completes.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : sha256_msg_padder_if.slave (word stream in, block bus out)
// ---------------------------------------------------------------------------
module sha256_msg_padder (
  input logic               clk,
  input logic               reset_n,
  sha256_msg_padder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t       r_state;
  state_t       w_nextState;

  logic [3:0]   r_widx;
  logic [63:0]  r_len;
  logic         r_needLen;
  logic         r_first;
  logic         r_markOwed;
  logic         r_blkFirst;
  logic         r_blkLast;
  logic [31:0]  r_words [16];

  logic         w_accept;
  logic [2:0]   w_nBytes;
  logic [5:0]   w_lenAdd;
  logic [31:0]  w_fillWord;
  logic         w_padLenOk;
  logic [31:0]  w_padWord;

  // Decode the incoming word: effective byte count (out-of-range counts mean
  // a full word), the bit-length increment, and the stored form of a short
  // last word with the marker inserted and the garbage bytes cleared.
  always_comb begin
    w_accept   = (r_state == ST_FILL) && bus.in_valid;
    w_nBytes   = 3'd4;
    if ((bus.in_bytes >= 3'd1) && (bus.in_bytes <= 3'd3)) begin
      w_nBytes = bus.in_bytes;
    end
    w_lenAdd   = bus.in_last ? {w_nBytes, 3'b000} : 6'd32;
    w_fillWord = bus.in_data;
    if (bus.in_last) begin
      case (w_nBytes)
        3'd1:    w_fillWord = {bus.in_data[31:24], 24'h800000};
        3'd2:    w_fillWord = {bus.in_data[31:16], 16'h8000};
        3'd3:    w_fillWord = {bus.in_data[31:8], 8'h80};
        default: w_fillWord = bus.in_data;
      endcase
    end
  end

  // Pad word for the current slot. The length may only go into slots 14/15
  // once the marker sits earlier in the same block; if the marker itself
  // lands in 14 or 15 the length is deferred to a length-only block.
  always_comb begin
    w_padLenOk = !r_markOwed && !r_needLen;
    w_padWord  = 32'h0;
    if (r_markOwed) begin
      w_padWord = 32'h8000_0000;
    end else if (w_padLenOk && (r_widx == 4'd14)) begin
      w_padWord = r_len[63:32];
    end else if (w_padLenOk && (r_widx == 4'd15)) begin
      w_padWord = r_len[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. After the core finishes, a block that still owes the
  // marker (full last word in slot 15) or the length goes back to PAD.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_accept && (r_widx == 4'd15)) begin
          w_nextState = ST_ISSUE;
        end else if (w_accept && bus.in_last) begin
          w_nextState = ST_PAD;
        end
      end
      ST_PAD: begin
        if (r_widx == 4'd15) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: w_nextState = ST_WAIT;
      ST_WAIT: begin
        if (bus.blk_done) begin
          w_nextState = (r_needLen || r_markOwed) ? ST_PAD : ST_FILL;
        end
      end
      default: w_nextState = ST_FILL;
    endcase
  end

  // Block buffer, slot pointer, length counter and message flags. The buffer
  // is only written in FILL and PAD, so it is frozen while the core reads it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_widx     <= 4'd0;
      r_len      <= 64'd0;
      r_needLen  <= 1'b0;
      r_first    <= 1'b1;
      r_markOwed <= 1'b0;
      r_blkFirst <= 1'b0;
      r_blkLast  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_words[i] <= 32'h0;
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_words[r_widx] <= w_fillWord;
            r_len           <= r_len + {58'd0, w_lenAdd};
            r_widx          <= r_widx + 4'd1;
            if (bus.in_last) begin
              r_markOwed <= (w_nBytes == 3'd4);
              if ((w_nBytes != 3'd4) && (r_widx >= 4'd14)) begin
                r_needLen <= 1'b1;
              end
            end
          end
        end
        ST_PAD: begin
          r_words[r_widx] <= w_padWord;
          r_widx          <= r_widx + 4'd1;
          if (r_markOwed) begin
            r_markOwed <= 1'b0;
            if (r_widx >= 4'd14) begin
              r_needLen <= 1'b1;
            end
          end
          if ((r_widx == 4'd15) && w_padLenOk) begin
            r_blkLast <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.blk_done) begin
            r_widx    <= 4'd0;
            r_blkLast <= 1'b0;
            if (r_needLen) begin
              r_needLen <= 1'b0;
            end else if (!r_markOwed && r_blkLast) begin
              r_len   <= 64'd0;
              r_first <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Entering ISSUE latches whether this block opens a message.
      if (w_nextState == ST_ISSUE) begin
        r_blkFirst <= r_first;
        r_first    <= 1'b0;
      end
    end
  end

  // Outputs. in_ready is gated by reset_n so it is low throughout reset.
  always_comb begin
    bus.in_ready  = reset_n && (r_state == ST_FILL);
    bus.blk_start = (r_state == ST_ISSUE);
    bus.blk_first = r_blkFirst;
    bus.blk_last  = r_blkLast;
    bus.blk_data  = '0;
    for (int i = 0; i < 16; i++) begin
      bus.blk_data[32*i +: 32] = r_words[i];
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
// Directed bench for the SHA-256 message padder: reset values, short and
// block-boundary messages, latency, backpressure, reset in WAIT and length
// wrap. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic reset_n;
  int   nCompared   = 0;
  int   nMismatched = 0;

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  sha256_msg_padder_if bus();

  sha256_msg_padder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Message byte j has value j, so word i holds bytes 4i..4i+3.
  function automatic logic [31:0] msg_word(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // Offer one word and hold it until the padder accepts it.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int waitCycles;
    waitCycles      = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_last     = last;
    bus.in_bytes    = nb;
    while ((bus.in_ready !== 1'b1) && (waitCycles < 100)) begin
      @(negedge clk);
      waitCycles++;
    end
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
  endtask

  // Send words 0..n-1 of the byte-index message, full last word, optional gaps.
  task automatic send_full_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        @(negedge clk);
      end
      send_word(msg_word(i), (i == n - 1), 3'd4);
    end
  endtask

  // Count falling edges until blk_start, bounded; snapshot the block.
  task automatic wait_start(output logic [511:0] blk, output logic f, output logic l,
                            output int cycles);
    cycles = 0;
    while ((bus.blk_start !== 1'b1) && (cycles < 200)) begin
      @(negedge clk);
      cycles++;
    end
    blk = bus.blk_data;
    f   = bus.blk_first;
    l   = bus.blk_last;
  endtask

  // One-cycle completion pulse, raised once the padder is in WAIT.
  task automatic pulse_done();
    @(negedge clk);
    bus.blk_done = 1'b1;
    @(negedge clk);
    bus.blk_done = 1'b0;
  endtask

  // Reset values while reset_n is low, then in_ready after release.
  task automatic test_reset();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.in_bytes = 3'd0;
    bus.blk_done = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.in_ready !== 1'b0) begin
      $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); nMismatched++;
    end
    nCompared++;
    if (bus.blk_start !== 1'b0) begin
      $display("[TB] FAIL reset_blk_start got %b want 0", bus.blk_start); nMismatched++;
    end
    nCompared++;
    if ({bus.blk_first, bus.blk_last} !== 2'b00) begin
      $display("[TB] FAIL reset_flags got %b%b want 00", bus.blk_first, bus.blk_last); nMismatched++;
    end
    nCompared++;
    if (bus.blk_data !== 512'd0) begin
      $display("[TB] FAIL reset_blk_data got %h want 0", bus.blk_data); nMismatched++;
    end
    nCompared++;
    reset_n = 1'b1;
    @(negedge clk);
    if (bus.in_ready !== 1'b1) begin
      $display("[TB] FAIL post_reset_in_ready got %b want 1", bus.in_ready); nMismatched++;
    end
    nCompared++;
  endtask

  // "abc": a single short last word; a stray blk_done in FILL must be ignored.
  task automatic test_abc();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    pulse_done();
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[31:0]    = 32'h6162_6380;
    expBlk[511:480] = 32'h0000_0018;
    if (cyc !== 15) begin
      $display("[TB] FAIL abc_latency got %0d want 15", cyc); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL abc_block got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b11) begin
      $display("[TB] FAIL abc_flags got %b%b want 11", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // 55 bytes: the marker fits in word 13 and the length in the same block.
  task automatic test_55_bytes();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    logic [31:0] w13;
    for (int i = 0; i < 13; i++) begin
      send_word(msg_word(i), 1'b0, 3'd0);
    end
    w13 = msg_word(13);
    send_word({w13[31:8], 8'hEE}, 1'b1, 3'd3);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    for (int i = 0; i < 13; i++) begin
      expBlk[32*i +: 32] = msg_word(i);
    end
    expBlk[32*13 +: 32] = 32'h3435_3680;
    expBlk[32*15 +: 32] = 32'h0000_01B8;
    if (cyc !== 2) begin
      $display("[TB] FAIL b55_latency got %0d want 2", cyc); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL b55_block got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b11) begin
      $display("[TB] FAIL b55_flags got %b%b want 11", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // 56 bytes: marker lands in word 14, so the length needs its own block.
  // Also checks in_ready low and blk_data frozen while the core reads.
  task automatic test_56_bytes(input bit gaps);
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    send_full_words(14, gaps);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    for (int i = 0; i < 14; i++) begin
      expBlk[32*i +: 32] = msg_word(i);
    end
    expBlk[32*14 +: 32] = 32'h8000_0000;
    if (cyc !== 2) begin
      $display("[TB] FAIL b56_latency got %0d want 2 (gaps=%0d)", cyc, gaps); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL b56_block1 got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b10) begin
      $display("[TB] FAIL b56_flags1 got %b%b want 10", f, l); nMismatched++;
    end
    nCompared++;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ((bus.blk_data !== blk) || (bus.in_ready !== 1'b0)) begin
        $display("[TB] FAIL b56_hold cycle %0d got ready=%b data=%h want ready=0 data=%h",
                 c, bus.in_ready, bus.blk_data, blk);
        nMismatched++;
      end
      nCompared++;
    end
    bus.blk_done = 1'b1;
    if (bus.in_ready !== 1'b0) begin
      $display("[TB] FAIL b56_ready_at_done got %b want 0", bus.in_ready); nMismatched++;
    end
    nCompared++;
    @(negedge clk);
    bus.blk_done = 1'b0;
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[32*15 +: 32] = 32'h0000_01C0;
    if (cyc !== 16) begin
      $display("[TB] FAIL b56_len_latency got %0d want 16", cyc); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL b56_block2 got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b01) begin
      $display("[TB] FAIL b56_flags2 got %b%b want 01", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // Same 56-byte message with random idle cycles between words.
  task automatic test_backpressure();
    test_56_bytes(1'b1);
  endtask

  // 64 bytes: data block issues right after word 16; held blk_done counts once.
  task automatic test_64_bytes();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    send_full_words(16, 1'b0);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    for (int i = 0; i < 16; i++) begin
      expBlk[32*i +: 32] = msg_word(i);
    end
    if (cyc !== 0) begin
      $display("[TB] FAIL b64_latency got %0d want 0", cyc); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL b64_block1 got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b10) begin
      $display("[TB] FAIL b64_flags1 got %b%b want 10", f, l); nMismatched++;
    end
    nCompared++;
    @(negedge clk);
    bus.blk_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.blk_done = 1'b0;
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[31:0]        = 32'h8000_0000;
    expBlk[32*15 +: 32] = 32'h0000_0200;
    if (cyc !== 15) begin
      $display("[TB] FAIL b64_pad_latency got %0d want 15", cyc); nMismatched++;
    end
    nCompared++;
    if (blk !== expBlk) begin
      $display("[TB] FAIL b64_block2 got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b01) begin
      $display("[TB] FAIL b64_flags2 got %b%b want 01", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // in_bytes = 0 on the last word means a full word.
  task automatic test_bytes_zero();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[31:0]        = 32'hDEAD_BEEF;
    expBlk[63:32]       = 32'h8000_0000;
    expBlk[32*15 +: 32] = 32'h0000_0020;
    if (blk !== expBlk) begin
      $display("[TB] FAIL bytes0_block got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b11) begin
      $display("[TB] FAIL bytes0_flags got %b%b want 11", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // Length counter preset near 2^64 wraps when "abc" adds 24 bits.
  task automatic test_rollover();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    force dut.r_len = 64'hFFFF_FFFF_FFFF_FFF0;
    #1;
    release dut.r_len;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[31:0]        = 32'h6162_6380;
    expBlk[32*15 +: 32] = 32'h0000_0008;
    if (blk !== expBlk) begin
      $display("[TB] FAIL rollover_block got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // Reset dropped in WAIT clears outputs at once; next message starts clean.
  task automatic test_reset_wait();
    logic [511:0] blk, expBlk;
    logic f, l;
    int cyc;
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_start(blk, f, l, cyc);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    if ({bus.in_ready, bus.blk_start, bus.blk_first, bus.blk_last} !== 4'b0000) begin
      $display("[TB] FAIL rstwait_ctrl got %b want 0000",
               {bus.in_ready, bus.blk_start, bus.blk_first, bus.blk_last});
      nMismatched++;
    end
    nCompared++;
    if (bus.blk_data !== 512'd0) begin
      $display("[TB] FAIL rstwait_data got %h want 0", bus.blk_data); nMismatched++;
    end
    nCompared++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_word(32'h41FF_FFFF, 1'b1, 3'd1);
    wait_start(blk, f, l, cyc);
    expBlk = '0;
    expBlk[31:0]        = 32'h4180_0000;
    expBlk[32*15 +: 32] = 32'h0000_0008;
    if (blk !== expBlk) begin
      $display("[TB] FAIL rstwait_next_block got %h want %h", blk, expBlk); nMismatched++;
    end
    nCompared++;
    if ({f, l} !== 2'b11) begin
      $display("[TB] FAIL rstwait_next_flags got %b%b want 11", f, l); nMismatched++;
    end
    nCompared++;
    pulse_done();
  endtask

  // Sequence of scenarios followed by the summary.
  initial begin
    test_reset();
    test_abc();
    test_55_bytes();
    test_56_bytes(1'b0);
    test_backpressure();
    test_64_bytes();
    test_bytes_zero();
    test_rollover();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 compression core. Accepts a message as a stream of big-endian 32-bit words with a valid/ready handshake, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length), and assembles 512-bit blocks. It presents one block at a time on the core's `start`/`data_in`/`done` interface, holding each block until the core reports completion.

## Interface
- No parameters.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous reset, active-low.
- `in_valid` input 1: `in_data` word valid.
- `in_ready` output 1: padder accepts a word this cycle.
- `in_data` input 32: message word, first byte in [31:24].
- `in_last` input 1: final word of the message.
- `in_bytes` input 3: valid bytes in the last word, 1..4. Only sampled with `in_last`. Values 0 and 5..7 are treated as 4.
- `blk_data` output 512: block for the core; word i is at [32*i +: 32].
- `blk_start` output 1: one-cycle start pulse to the core.
- `blk_first` output 1: the current block is the first block of a message. Top level re-initialises the core's hash state on it.
- `blk_last` output 1: the current block is the final block of a message.
- `blk_done` input 1: core completion, sampled as a level.

## Operation
- States:
  - FILL: accept words.
  - PAD: write pad/length words, one per cycle.
  - ISSUE: drive `blk_start`.
  - WAIT: wait for the core.
- Registers:
  - `widx[3:0]`: word slot being written.
  - `len[63:0]`: message length in bits.
  - `need_len`: a length-only block is still owed.
  - `first`: next issued block opens a message.
- FILL: `in_ready`=1. Each handshake writes slot `widx`, adds 32 bits to `len` (8*`in_bytes` on the last word), and increments `widx`.
  - Non-last word into slot 15 -> ISSUE.
  - Last word with n<4 valid bytes: byte n of the slot becomes 0x80, bytes after it become 0x00. The word is stored masked, so garbage below the valid bytes is discarded. -> PAD with `widx`+1.
  - Last word with n=4: stored as-is -> PAD at `widx`+1, with the next written word being 0x80000000.
- PAD, each cycle writes slot `widx`:
  - 0x80000000 if the marker is still owed.
  - `len[63:32]` at slot 14 and `len[31:0]` at slot 15, but only if the marker is already placed and slot 14 was reached with the marker before it.
  - 0 otherwise.
- PAD block-split rule: if the marker lands in slot 14 or 15, set `need_len`, zero-fill through slot 15, and issue. The next block is all zero except slots 14/15 = `len`.
- ISSUE: one cycle -> WAIT.
- WAIT: on `blk_done`:
  - Ordinary data block -> FILL, `widx`=0.
  - `need_len` -> PAD (writing zeros then length), `widx`=0.
  - `blk_last` block -> FILL, `len`=0, `first`=1, `widx`=0.
- Flag rules:
  - `first` clears when ISSUE is entered.
  - `blk_last` is set for a block containing the length words.
- Arithmetic: `len` is 64-bit and wraps modulo 2^64. No overflow flag.
- `blk_data` is registered. It changes only in FILL/PAD, so it is stable from `blk_start` until `blk_done`. This covers the core's 16-cycle read window.

## Timing
- Reset values:
  - State FILL; `in_ready`=0 while `reset_n` low, 1 from the first cycle after release.
  - `blk_start`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0.
  - `len`=0, `widx`=0, `first`=1, `need_len`=0.
- Reset asserted mid-block or mid-WAIT aborts immediately. Partial data is discarded and `blk_start` never re-fires for the aborted block.
- Latency:
  - 16th data word accepted at cycle T -> `blk_start`=1 at T+1.
  - Last word at slot k (k≤13) at T -> PAD occupies cycles T+1..T+(15-k) -> `blk_start` at T+16-k.
- `blk_first`/`blk_last` are valid from the `blk_start` cycle until `blk_done`.
- `in_ready`=0 in PAD, ISSUE and WAIT. The word after `blk_done` is accepted no earlier than the cycle after `blk_done`.
- `blk_done` in any state other than WAIT is ignored.
- A single-cycle `blk_done` is sufficient. A held `blk_done` is consumed once, since the next WAIT is at least 2 cycles later.

## Test plan
- "abc": one word 0x61626300, `in_last`=1, `in_bytes`=3.
  - Expect one block: w0=0x61626380, w1..w14=0, w15=0x00000018; `blk_first`=`blk_last`=1.
  - With the core, digest = ba7816bf...f20015ad.
- 55-byte message (14 words, last `in_bytes`=3) -> one block: w13 low byte 0x80, w14=0, w15=0x000001B8.
- 56-byte message (14 full words) -> two blocks.
  - Block 1: w14=0x80000000, w15=0, `blk_last`=0.
  - Block 2: all zero except w15=0x000001C0, `blk_first`=0, `blk_last`=1.
- 64-byte message (16 full words) -> data block issued 1 cycle after the 16th word; second block w0=0x80000000, w15=0x00000200.
- Backpressure:
  - `in_valid` random 50%: blocks are identical to the back-to-back case.
  - `in_ready`=0 from `blk_start` through the `blk_done` cycle.
  - `blk_data` is unchanged for all 16 cycles after `blk_start`.
- Reset and rollover:
  - Drop `reset_n` during WAIT -> all outputs at reset values the same cycle; the next message is issued with `blk_first`=1 and `len` starting from 0.
  - Message of 2^61 bytes is not practical; instead force `len` near 2^64 and check the wrap.
